pipeline_ctrl: RTL and testbench

PIPELINE_CTRL -- requirements
Module: pipeline_ctrl

---
 rtl/pipeline_ctrl_pkg.sv | 26 ++
 rtl/pipeline_ctrl_load_use.sv | 28 ++
 rtl/pipeline_ctrl.sv | 169 ++++++++++++++++
 tb/tb_pipeline_ctrl.sv | 205 ++++++++++++++++++++
 4 files changed

// File: rtl/pipeline_ctrl_pkg.sv
// Shared definitions for the pipeline hazard / memory-wait controller:
// FSM state encoding, default timeout and a width helper.
package pipeline_ctrl_pkg;

  // Register index width of the integer register file.
  localparam int REG_IDX_W = 5;

  // Default number of data-memory wait cycles tolerated before timeout.
  localparam int MAX_WAIT_DEF = 15;

  // Controller states: normal flow, waiting on data memory, timed out.
  typedef enum logic [1:0] {
    ST_RUN      = 2'd0,
    ST_MEM_WAIT = 2'd1,
    ST_ERR      = 2'd2
  } state_t;

  // Bits needed to hold a wait count from 0 up to max_wait inclusive.
  function automatic int wait_cnt_width(input int max_wait);
    if (max_wait < 1) begin
      return 1;
    end
    return $clog2(max_wait + 1);
  endfunction

endpackage

// File: rtl/pipeline_ctrl_load_use.sv
// Load-use hazard detector: flags when the instruction in ID reads a
// register that the load currently in EX has not yet produced.
// Register x0 is hard-wired to zero, so it never creates a hazard.
module load_use_detect
  import pipeline_ctrl_pkg::*;
(
  input  logic [REG_IDX_W-1:0] id_rs1,
  input  logic [REG_IDX_W-1:0] id_rs2,
  input  logic                 id_uses_rs1,
  input  logic                 id_uses_rs2,
  input  logic [REG_IDX_W-1:0] ex_rd,
  input  logic                 ex_is_load,
  output logic                 hazard
);

  logic rd_live;
  logic hit_rs1;
  logic hit_rs2;

  // Compare each used source against a non-zero load destination.
  always_comb begin
    rd_live = ex_is_load && (ex_rd != '0);
    hit_rs1 = id_uses_rs1 && (id_rs1 == ex_rd);
    hit_rs2 = id_uses_rs2 && (id_rs2 == ex_rd);
    hazard  = rd_live && (hit_rs1 || hit_rs2);
  end

endmodule

// File: rtl/pipeline_ctrl.sv
// Pipeline control unit: memory-wait freeze with timeout, branch/jump
// redirect flush and load-use stall, plus optional performance counters.
//
// Priority (highest first): reset, memory freeze (incl. ERR), redirect,
// load-use, normal flow. All control outputs are combinational from the
// current state and inputs; mem_err and the counters are registered.
//
// Build option: define PIPE_PERF_CNT_EN to implement stall_cnt, flush_cnt
// and wait_cnt. Without it those ports read constant zero and no counter
// registers exist.
//
// dbg_state exposes the FSM state for observation.
module pipeline_ctrl
  import pipeline_ctrl_pkg::*;
#(
  parameter int MAX_WAIT = MAX_WAIT_DEF,
  parameter int CNT_W    = 32
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [REG_IDX_W-1:0] id_rs1,
  input  logic [REG_IDX_W-1:0] id_rs2,
  input  logic                 id_uses_rs1,
  input  logic                 id_uses_rs2,
  input  logic [REG_IDX_W-1:0] ex_rd,
  input  logic                 ex_is_load,
  input  logic                 ex_redirect,
  input  logic                 mem_req,
  input  logic                 mem_ready,
  output logic                 pc_we,
  output logic                 if_id_stall,
  output logic                 if_id_nop,
  output logic                 id_ex_nop,
  output logic                 be_hold,
  output logic                 mem_wb_bubble,
  output logic                 mem_err,
  output logic [CNT_W-1:0]     stall_cnt,
  output logic [CNT_W-1:0]     flush_cnt,
  output logic [CNT_W-1:0]     wait_cnt,
  output state_t               dbg_state
);

  localparam int WC_W = wait_cnt_width(MAX_WAIT);

  state_t          state;
  logic [WC_W-1:0] wait_ctr;
  logic            load_use;
  logic            frozen;

  load_use_detect u_load_use (
    .id_rs1      (id_rs1),
    .id_rs2      (id_rs2),
    .id_uses_rs1 (id_uses_rs1),
    .id_uses_rs2 (id_uses_rs2),
    .ex_rd       (ex_rd),
    .ex_is_load  (ex_is_load),
    .hazard      (load_use)
  );

  // Freeze decision: a fresh miss in RUN, any not-ready cycle while
  // waiting, and every cycle once timed out.
  always_comb begin
    frozen = 1'b1;
    case (state)
      ST_RUN:      frozen = mem_req && !mem_ready;
      ST_MEM_WAIT: frozen = !mem_ready;
      ST_ERR:      frozen = 1'b1;
      default:     frozen = 1'b1;
    endcase
  end

  // Control outputs in priority order; redirect masks load-use because
  // the younger instruction in ID is being discarded anyway.
  always_comb begin
    pc_we         = 1'b1;
    if_id_stall   = 1'b0;
    if_id_nop     = 1'b0;
    id_ex_nop     = 1'b0;
    be_hold       = 1'b0;
    mem_wb_bubble = 1'b0;
    if (!rst_n) begin
      pc_we         = 1'b0;
      if_id_nop     = 1'b1;
      id_ex_nop     = 1'b1;
      mem_wb_bubble = 1'b1;
    end else if (frozen) begin
      pc_we         = 1'b0;
      if_id_stall   = 1'b1;
      be_hold       = 1'b1;
      mem_wb_bubble = 1'b1;
    end else if (ex_redirect) begin
      if_id_nop = 1'b1;
      id_ex_nop = 1'b1;
    end else if (load_use) begin
      pc_we       = 1'b0;
      if_id_stall = 1'b1;
      id_ex_nop   = 1'b1;
    end
  end

  // Memory-wait FSM: counts consecutive not-ready cycles of one access
  // (the RUN cycle that detects the miss is wait 1) and traps into ERR
  // when another not-ready cycle arrives after MAX_WAIT waits.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= ST_RUN;
      wait_ctr <= '0;
      mem_err  <= 1'b0;
    end else begin
      case (state)
        ST_RUN: begin
          if (mem_req && !mem_ready) begin
            state    <= ST_MEM_WAIT;
            wait_ctr <= WC_W'(1);
          end
        end
        ST_MEM_WAIT: begin
          if (mem_ready) begin
            state    <= ST_RUN;
            wait_ctr <= '0;
          end else if (wait_ctr == WC_W'(MAX_WAIT)) begin
            state   <= ST_ERR;
            mem_err <= 1'b1;
          end else begin
            wait_ctr <= wait_ctr + WC_W'(1);
          end
        end
        ST_ERR: begin
          mem_err <= 1'b1;
        end
        default: begin
          state    <= ST_RUN;
          wait_ctr <= '0;
        end
      endcase
    end
  end

  assign dbg_state = state;

`ifdef PIPE_PERF_CNT_EN
  logic count_stall;
  logic count_flush;

  // Events that actually took effect this cycle.
  always_comb begin
    count_flush = !frozen && ex_redirect;
    count_stall = !frozen && !ex_redirect && load_use;
  end

  // Free-running event counters, wrapping at 2^CNT_W.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stall_cnt <= '0;
      flush_cnt <= '0;
      wait_cnt  <= '0;
    end else begin
      if (count_stall) stall_cnt <= stall_cnt + CNT_W'(1);
      if (count_flush) flush_cnt <= flush_cnt + CNT_W'(1);
      if (frozen)      wait_cnt  <= wait_cnt + CNT_W'(1);
    end
  end
`else
  assign stall_cnt = '0;
  assign flush_cnt = '0;
  assign wait_cnt  = '0;
`endif

endmodule

// File: tb/tb_pipeline_ctrl.sv
// Testbench for pipeline_ctrl: directed scenarios followed by randomized
// traffic. A driver applies one input vector per cycle and pushes the
// reference model's expected response; a monitor pops and compares on the
// falling edge. Define PIPE_PERF_CNT_EN here too when the DUT has counters.
module tb_pipeline_ctrl;
  import pipeline_ctrl_pkg::*;

  localparam int TB_MAX_WAIT = 4;
  localparam int TB_CNT_W    = 8;
  localparam int EXP_W       = 6 + 1 + 3 * TB_CNT_W + 2;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  // ---------------- DUT signals ----------------
  logic [4:0] id_rs1 = '0, id_rs2 = '0, ex_rd = '0;
  logic id_uses_rs1 = 1'b0, id_uses_rs2 = 1'b0, ex_is_load = 1'b0;
  logic ex_redirect = 1'b0, mem_req = 1'b0, mem_ready = 1'b1;
  logic pc_we, if_id_stall, if_id_nop, id_ex_nop, be_hold, mem_wb_bubble, mem_err;
  logic [TB_CNT_W-1:0] stall_cnt, flush_cnt, wait_cnt;
  state_t dbg_state;

  pipeline_ctrl #(.MAX_WAIT(TB_MAX_WAIT), .CNT_W(TB_CNT_W)) dut (
    .clk(clk), .rst_n(rst_n),
    .id_rs1(id_rs1), .id_rs2(id_rs2),
    .id_uses_rs1(id_uses_rs1), .id_uses_rs2(id_uses_rs2),
    .ex_rd(ex_rd), .ex_is_load(ex_is_load), .ex_redirect(ex_redirect),
    .mem_req(mem_req), .mem_ready(mem_ready),
    .pc_we(pc_we), .if_id_stall(if_id_stall), .if_id_nop(if_id_nop),
    .id_ex_nop(id_ex_nop), .be_hold(be_hold), .mem_wb_bubble(mem_wb_bubble),
    .mem_err(mem_err), .stall_cnt(stall_cnt), .flush_cnt(flush_cnt),
    .wait_cnt(wait_cnt), .dbg_state(dbg_state)
  );

  // ---------------- scoreboard state ----------------
  logic [EXP_W-1:0] exp_q[$];
  int checks = 0;
  int errors = 0;

  // ---------------- reference model ----------------
  // m_err: timed out; m_waits: not-ready cycles seen for the access in
  // flight (0 = no access outstanding); event totals as plain integers.
  bit m_err = 1'b0;
  int m_waits = 0;
  int m_stalls = 0, m_flushes = 0, m_frozen = 0;

  // Apply one cycle of inputs, then record what the DUT must show.
  task automatic step(input logic rst, input logic [4:0] rs1, input logic [4:0] rs2,
                      input logic u1, input logic u2, input logic [4:0] erd,
                      input logic ld, input logic redir, input logic mreq,
                      input logic mrdy);
    logic [5:0] ctrl;
    logic [TB_CNT_W-1:0] c_stall, c_flush, c_wait;
    logic [1:0] st;
    bit frozen, hazard;
    @(posedge clk);
    #1;
    rst_n = rst; id_rs1 = rs1; id_rs2 = rs2; id_uses_rs1 = u1; id_uses_rs2 = u2;
    ex_rd = erd; ex_is_load = ld; ex_redirect = redir; mem_req = mreq; mem_ready = mrdy;

    if (!rst) begin
      m_err = 1'b0; m_waits = 0; m_stalls = 0; m_flushes = 0; m_frozen = 0;
      // order: pc_we, if_id_stall, if_id_nop, id_ex_nop, be_hold, mem_wb_bubble
      ctrl = 6'b001101;
      st   = ST_RUN;
    end else begin
      hazard = ld && (erd != 0) && ((u1 && rs1 == erd) || (u2 && rs2 == erd));
      frozen = m_err || (!mrdy && (m_waits > 0 || mreq));
      if (frozen)      ctrl = 6'b010011;
      else if (redir)  ctrl = 6'b101100;
      else if (hazard) ctrl = 6'b010100;
      else             ctrl = 6'b100000;
      st = m_err ? ST_ERR : (m_waits > 0 ? ST_MEM_WAIT : ST_RUN);
    end

`ifdef PIPE_PERF_CNT_EN
    c_stall = TB_CNT_W'(m_stalls);
    c_flush = TB_CNT_W'(m_flushes);
    c_wait  = TB_CNT_W'(m_frozen);
`else
    c_stall = '0; c_flush = '0; c_wait = '0;
`endif
    exp_q.push_back({ctrl, m_err, c_stall, c_flush, c_wait, st});

    // advance the model to what holds after this clock edge
    if (rst) begin
      if (frozen) m_frozen++;
      else if (redir) m_flushes++;
      else if (hazard) m_stalls++;
      if (!m_err) begin
        if (!frozen) m_waits = 0;
        else if (m_waits == TB_MAX_WAIT) m_err = 1'b1;
        else m_waits++;
      end
    end
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1, 0, 0, 0, 0, 0, 0, 0, 0, 1);
  endtask

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, got, want, $time);
    end
  endtask

  // ---------------- monitor ----------------
  initial begin
    logic [EXP_W-1:0] e;
    forever begin
      @(negedge clk);
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        check("ctrl", 32'({pc_we, if_id_stall, if_id_nop, id_ex_nop, be_hold, mem_wb_bubble}),
              32'(e[EXP_W-1 -: 6]));
        check("mem_err", 32'(mem_err), 32'(e[EXP_W-7]));
        check("counters", 32'({stall_cnt, flush_cnt, wait_cnt}), 32'(e[2 +: 3*TB_CNT_W]));
        check("state", 32'(dbg_state), 32'(e[1:0]));
      end
    end
  end

  // ---------------- stimulus ----------------
  initial begin
    bit slow;
    // reset held for two cycles, then released
    step(0, 0, 0, 0, 0, 0, 0, 0, 0, 1);
    step(0, 0, 0, 0, 0, 0, 0, 0, 0, 1);
    idle(2);

    // load-use on rs1 = x5: one stall cycle, then the bubble clears EX
    step(1, 5, 0, 1, 0, 5, 1, 0, 0, 1);
    idle(1);
    // load-use on rs2
    step(1, 1, 7, 1, 1, 7, 1, 0, 0, 1);
    idle(1);
    // load to x0 never stalls
    step(1, 0, 0, 1, 1, 0, 1, 0, 0, 1);
    // matching index but source not used
    step(1, 9, 9, 0, 0, 9, 1, 0, 0, 1);
    // redirect with load-use present: flush wins
    step(1, 5, 0, 1, 0, 5, 1, 1, 0, 1);
    idle(1);

    // memory wait of 3 not-ready cycles, released in the ready cycle
    for (int i = 0; i < 3; i++) step(1, 0, 0, 0, 0, 0, 0, 0, 1, 0);
    step(1, 0, 0, 0, 0, 0, 0, 0, 1, 1);
    idle(1);

    // freeze beats redirect; redirect applied in the release cycle
    for (int i = 0; i < 2; i++) step(1, 3, 0, 1, 0, 3, 1, 1, 1, 0);
    step(1, 3, 0, 1, 0, 3, 1, 1, 1, 1);
    idle(1);

    // exactly MAX_WAIT waits then ready: no error
    for (int i = 0; i < TB_MAX_WAIT; i++) step(1, 0, 0, 0, 0, 0, 0, 0, 1, 0);
    step(1, 0, 0, 0, 0, 0, 0, 0, 1, 1);
    idle(1);

    // timeout: memory never ready, ERR sticks even once ready returns
    for (int i = 0; i < TB_MAX_WAIT + 4; i++) step(1, 0, 0, 0, 0, 0, 0, 0, 1, 0);
    step(1, 2, 0, 1, 0, 2, 1, 1, 1, 1);
    step(1, 0, 0, 0, 0, 0, 0, 0, 0, 1);
    // reset clears mem_err, first cycle after release is RUN
    step(0, 0, 0, 0, 0, 0, 0, 0, 1, 0);
    idle(2);

    // reset in the middle of a memory wait
    step(1, 0, 0, 0, 0, 0, 0, 0, 1, 0);
    step(1, 0, 0, 0, 0, 0, 0, 0, 1, 0);
    step(0, 0, 0, 0, 0, 0, 0, 0, 1, 0);
    idle(1);

    // randomized traffic with alternating fast/slow memory phases
    slow = 1'b0;
    for (int n = 0; n < 1500; n++) begin
      if (n % 100 == 0) slow = ~slow;
      step(($urandom_range(0, 149) != 0),
           5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)),
           1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
           5'($urandom_range(0, 3)), 1'($urandom_range(0, 1)),
           ($urandom_range(0, 5) == 0), ($urandom_range(0, 3) == 0),
           slow ? ($urandom_range(0, 7) == 0) : ($urandom_range(0, 2) != 0));
    end
    idle(2);

    // drain: every pushed expectation must have been compared
    for (int i = 0; i < 10 && exp_q.size() > 0; i++) @(negedge clk);
    @(negedge clk);
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL drain: %0d expectations left, expected 0", exp_q.size());
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
